// File: rtl/pe_mc_conv.sv
// Multi-channel 1-D convolution PE: NUM_CH filter rows over one ifmap pad, optional upstream psum add and ReLU.
// Latency: FILT_LEN MAC cycles per output, plus one cycle after the psum_in accept when accumulation is on.
// Backpressure: stalls in OUT until psum_out_ready and in ACC until psum_in_valid; ifmap is refused when the pad is full.
module pe_mc_conv #(
    parameter int DATA_W      = 8,
    parameter int PSUM_W      = 20,
    parameter int FILT_LEN    = 3,
    parameter int IFMAP_DEPTH = 8,
    parameter int NUM_CH      = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_acc_en,
    input  logic              cfg_relu_en,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [DATA_W-1:0] if_data,
    input  logic              if_last,
    input  logic              psum_in_valid,
    output logic              psum_in_ready,
    input  logic [PSUM_W-1:0] psum_in_data,
    output logic              psum_out_valid,
    input  logic              psum_out_ready,
    output logic [PSUM_W-1:0] psum_out_data,
    output logic [CH_W-1:0]   psum_out_ch,
    input  logic              conv_continue,
    output logic              conv_done,
    output logic              error,
    output logic              full
);

    localparam int NW    = NUM_CH * FILT_LEN;
    localparam int WI_W  = (NW > 1) ? $clog2(NW) : 1;
    localparam int PI_W  = (IFMAP_DEPTH > 1) ? $clog2(IFMAP_DEPTH) : 1;
    localparam int CNT_W = $clog2(IFMAP_DEPTH + 1);
    localparam int K_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [2:0] {
        S_LOAD_W,
        S_LOAD_IF,
        S_MAC,
        S_ACC,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] w_mem [NW];
    logic signed [DATA_W-1:0] pad   [IFMAP_DEPTH];
    logic [WI_W-1:0]          w_cnt;
    logic [CNT_W-1:0]         if_cnt;
    logic [CNT_W-1:0]         p;
    logic [CH_W-1:0]          c;
    logic [K_W-1:0]           k;
    logic signed [PSUM_W-1:0] acc;
    logic [PSUM_W-1:0]        out_data;
    logic                     err_q;

    logic w_fire, if_fire, pin_fire, pout_fire;
    logic if_end, if_short, tap_last, ch_last, last_out;
    logic [WI_W-1:0]          w_idx;
    logic [PI_W-1:0]          pad_idx;
    logic signed [DATA_W-1:0] w_sel, x_sel;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [PSUM_W-1:0] prod_ext, acc_sum;
    logic [PSUM_W-1:0]        acc_psum;

    function automatic logic [PSUM_W-1:0] relu_f(input logic en, input logic [PSUM_W-1:0] x);
        return (en && x[PSUM_W-1]) ? '0 : x;
    endfunction

    assign w_fire    = w_valid && w_ready;
    assign if_fire   = if_valid && if_ready;
    assign pin_fire  = psum_in_valid && psum_in_ready;
    assign pout_fire = psum_out_valid && psum_out_ready;

    assign full     = (if_cnt == CNT_W'(IFMAP_DEPTH));
    assign if_end   = if_fire && (if_last || (if_cnt == CNT_W'(IFMAP_DEPTH - 1)));
    // if_cnt is the count before the word being accepted, so L = if_cnt + 1
    assign if_short = (if_cnt < CNT_W'(FILT_LEN - 1));
    assign tap_last = (k == K_W'(FILT_LEN - 1));
    assign ch_last  = (c == CH_W'(NUM_CH - 1));
    // if_cnt still holds L during compute, so the last position is L - FILT_LEN
    assign last_out = (p == (if_cnt - CNT_W'(FILT_LEN))) && ch_last;

    assign w_idx    = WI_W'(32'(c) * 32'(FILT_LEN) + 32'(k));
    assign pad_idx  = PI_W'(32'(p) + 32'(k));
    assign w_sel    = w_mem[w_idx];
    assign x_sel    = pad[pad_idx];
    assign prod     = w_sel * x_sel;
    assign prod_ext = PSUM_W'(prod);
    assign acc_sum  = acc + prod_ext;
    assign acc_psum = acc + psum_in_data;

    assign psum_out_data = out_data;
    assign psum_out_ch   = (state == S_OUT) ? c : '0;
    assign error         = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD_W;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        w_ready        = 1'b0;
        if_ready       = 1'b0;
        psum_in_ready  = 1'b0;
        psum_out_valid = 1'b0;
        conv_done      = 1'b0;
        case (state)
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_fire && (w_cnt == WI_W'(NW - 1))) state_nxt = S_LOAD_IF;
            end
            S_LOAD_IF: begin
                if_ready = !full;
                if (if_end) state_nxt = if_short ? S_DONE : S_MAC;
            end
            S_MAC: begin
                if (tap_last) state_nxt = cfg_acc_en ? S_ACC : S_OUT;
            end
            S_ACC: begin
                psum_in_ready = 1'b1;
                if (pin_fire) state_nxt = S_OUT;
            end
            S_OUT: begin
                psum_out_valid = 1'b1;
                if (pout_fire) state_nxt = last_out ? S_DONE : S_MAC;
            end
            S_DONE: begin
                conv_done = 1'b1;
                if (conv_continue) state_nxt = S_LOAD_IF;
            end
            default: state_nxt = S_LOAD_W;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NW; i++) w_mem[i] <= '0;
            for (int i = 0; i < IFMAP_DEPTH; i++) pad[i] <= '0;
            w_cnt    <= '0;
            if_cnt   <= '0;
            p        <= '0;
            c        <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
            err_q    <= 1'b0;
        end else begin
            if (w_fire) begin
                w_mem[w_cnt] <= w_data;
                w_cnt        <= w_cnt + WI_W'(1);
            end
            if (if_fire) begin
                pad[if_cnt[PI_W-1:0]] <= if_data;
                if_cnt                <= if_cnt + CNT_W'(1);
            end
            if (if_end) begin
                p   <= '0;
                c   <= '0;
                k   <= '0;
                acc <= '0;
            end
            if ((state == S_DONE) && conv_continue) if_cnt <= '0;
            if (state == S_MAC) begin
                acc <= acc_sum;
                k   <= tap_last ? '0 : k + K_W'(1);
                if (tap_last && !cfg_acc_en) out_data <= relu_f(cfg_relu_en, acc_sum);
            end
            if ((state == S_ACC) && pin_fire) out_data <= relu_f(cfg_relu_en, acc_psum);
            if ((state == S_OUT) && pout_fire) begin
                acc <= '0;
                k   <= '0;
                if (ch_last) begin
                    c <= '0;
                    p <= p + CNT_W'(1);
                end else begin
                    c <= c + CH_W'(1);
                end
            end
            // ifmap offered while the pad is busy is dropped and flagged
            if ((if_end && if_short) ||
                (if_valid && ((state == S_MAC) || (state == S_ACC) ||
                              (state == S_OUT) || (state == S_DONE))))
                err_q <= 1'b1;
        end
    end

endmodule
